// File: rtl/am_insert_ctrl.sv
// 100GbE PCS transmit alignment-marker inserter: forwards scrambled 66-bit blocks and
// emits one AM per lane every N_BLOCKS*N_ALIGNERS data blocks. Optional macro: AM_INSERT_BIP_EN.
module am_insert_ctrl #(
  parameter int N_ALIGNERS   = 20,
  parameter int N_BLOCKS     = 16383,
  parameter int NB_LANE_ID   = $clog2(N_ALIGNERS),
  parameter int NB_BLOCK_CNT = $clog2(N_BLOCKS*N_ALIGNERS)
) (
  input  logic                  i_clock,
  input  logic                  i_reset_n,
  input  logic                  i_enable,
  input  logic                  i_valid,
  input  logic [65:0]           i_data,
  output logic                  o_ready,
  output logic                  o_valid,
  output logic [65:0]           o_data,
  output logic                  o_am_flag,
  output logic [NB_LANE_ID-1:0] o_lane_id,
  output logic                  o_start_of_group
);

  localparam logic [NB_BLOCK_CNT-1:0] CNT_TERM  = NB_BLOCK_CNT'(N_BLOCKS*N_ALIGNERS-1);
  localparam logic [NB_LANE_ID-1:0]   LANE_LAST = NB_LANE_ID'(N_ALIGNERS-1);

  typedef enum logic {ST_INSERT, ST_DATA} state_t;

  state_t                  state, state_next;
  logic [NB_LANE_ID-1:0]   lane_cnt, lane_cnt_next;
  logic [NB_BLOCK_CNT-1:0] blk_cnt, blk_cnt_next;
  logic                    am_emit;
  logic                    accept;
  logic                    last_lane;
  logic [23:0]             am_m;
  logic [7:0]              bip3;
  logic [65:0]             am_block;

  // Returns {M2,M1,M0} so that M0 lands in the low byte of the payload.
  function automatic logic [23:0] am_const(input int lane);
    case (lane)
      0:       return 24'h2168C1;
      1:       return 24'h8E719D;
      2:       return 24'hE84B59;
      3:       return 24'h7B954D;
      4:       return 24'h0907F5;
      5:       return 24'hC214DD;
      6:       return 24'h264A9A;
      7:       return 24'h66457B;
      8:       return 24'h7624A0;
      9:       return 24'hFBC968;
      10:      return 24'h996CFD;
      11:      return 24'h5591B9;
      12:      return 24'hB2B95C;
      13:      return 24'hBDF81A;
      14:      return 24'hCAC783;
      15:      return 24'hCD3635;
      16:      return 24'h4C31C4;
      17:      return 24'hB7D6AD;
      18:      return 24'h2A665F;
      19:      return 24'hE5F0C0;
      default: return 24'h000000;
    endcase
  endfunction

  assign last_lane = (lane_cnt == LANE_LAST);
  assign am_m      = am_const(int'(lane_cnt));
  assign am_block  = {2'b01, ~bip3, ~am_m, bip3, am_m};

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state    <= ST_INSERT;
      lane_cnt <= '0;
      blk_cnt  <= '0;
    end else begin
      state    <= state_next;
      lane_cnt <= lane_cnt_next;
      blk_cnt  <= blk_cnt_next;
    end
  end

  always_comb begin
    state_next    = state;
    lane_cnt_next = lane_cnt;
    blk_cnt_next  = blk_cnt;
    am_emit       = 1'b0;
    accept        = 1'b0;
    o_ready       = 1'b0;
    if (i_enable) begin
      case (state)
        ST_INSERT: begin
          am_emit = 1'b1;
          if (last_lane) begin
            state_next    = ST_DATA;
            lane_cnt_next = '0;
            blk_cnt_next  = '0;
          end else begin
            lane_cnt_next = lane_cnt + NB_LANE_ID'(1);
          end
        end
        ST_DATA: begin
          o_ready = 1'b1;
          if (i_valid) begin
            accept        = 1'b1;
            blk_cnt_next  = blk_cnt + NB_BLOCK_CNT'(1);
            lane_cnt_next = last_lane ? '0 : lane_cnt + NB_LANE_ID'(1);
            // Terminal count is only looked at on an accepted block.
            if (blk_cnt == CNT_TERM) begin
              state_next    = ST_INSERT;
              lane_cnt_next = '0;
              blk_cnt_next  = '0;
            end
          end
        end
        default: state_next = ST_INSERT;
      endcase
    end
  end

`ifdef AM_INSERT_BIP_EN
  // Clause 82 BIP: bit j covers payload bits 8k+j; bits 3 and 4 also cover the two header bits.
  function automatic logic [7:0] bip_of(input logic [65:0] blk);
    logic [7:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r ^= blk[8*i +: 8];
    r[3] ^= blk[64];
    r[4] ^= blk[65];
    return r;
  endfunction

  logic [7:0] bip_acc [N_ALIGNERS];

  assign bip3 = bip_acc[lane_cnt];

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < N_ALIGNERS; i++) bip_acc[i] <= '0;
    end else if (am_emit) begin
      bip_acc[lane_cnt] <= bip_of(am_block);
    end else if (accept) begin
      bip_acc[lane_cnt] <= bip_acc[lane_cnt] ^ bip_of(i_data);
    end
  end
`else
  assign bip3 = 8'h00;
`endif

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_valid          <= 1'b0;
      o_data           <= '0;
      o_am_flag        <= 1'b0;
      o_lane_id        <= '0;
      o_start_of_group <= 1'b0;
    end else begin
      o_valid          <= am_emit | accept;
      o_am_flag        <= am_emit;
      o_start_of_group <= am_emit && (lane_cnt == '0);
      if (am_emit) begin
        o_data    <= am_block;
        o_lane_id <= lane_cnt;
      end else if (accept) begin
        o_data    <= i_data;
        o_lane_id <= lane_cnt;
      end
    end
  end

endmodule

// File: doc/am_insert_ctrl.md
# am_insert_ctrl

Transmit-side alignment marker inserter for the 100GbE PCS. It sits after the scrambler and before the TX lane distribution. It forwards scrambled 66-bit blocks, counts them, and every N_BLOCKS*N_ALIGNERS data blocks emits a group of N_ALIGNERS alignment-marker blocks, one per PCS lane. Upstream is stalled while a group is emitted. Its output is the stream that the RX-side AM lock FSM searches and locks to.

## Interface
Parameters:
- N_ALIGNERS, 20, number of PCS lanes and AM blocks per group
- N_BLOCKS, 16383, data blocks per lane between AM groups (use 4 in simulation)
- NB_LANE_ID, $clog2(N_ALIGNERS), lane index width
- NB_BLOCK_CNT, $clog2(N_BLOCKS*N_ALIGNERS), data block counter width

Ports:
- i_clock  in  1  block clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_enable  in  1  clock enable; when low, all state freezes
- i_valid  in  1  upstream block valid
- i_data  in  66  upstream block; [65:64] = sync header, [63:0] = payload
- o_ready  out  1  upstream may present a block (combinational from state and i_enable)
- o_valid  out  1  o_data valid
- o_data  out  66  output block (data or AM), same bit layout as i_data
- o_am_flag  out  1  current o_data is an AM block
- o_lane_id  out  NB_LANE_ID  lane of current o_data, equal to block index mod N_ALIGNERS
- o_start_of_group  out  1  pulses with the lane-0 AM block

## Operation
- States:
  - INSERT (reset state): emits AM blocks for lanes 0..N_ALIGNERS-1 on consecutive enabled cycles. When lane N_ALIGNERS-1 is emitted, moves to DATA and clears the data counter.
  - DATA: o_ready=1. Each accepted block (i_valid && o_ready && i_enable) is forwarded and increments the data counter. When the block with count N_BLOCKS*N_ALIGNERS-1 is accepted, moves to INSERT.
- AM block: sync header 2'b01. Payload bytes from LSB up are M0,M1,M2,BIP3,M4,M5,M6,BIP7, so M0 is at [7:0].
  - M0..M2 come from the per-lane constants in IEEE 802.3 Table 82-2. Lane 0 is C1,68,21.
  - M4..M6 = ~M0..~M2.
  - BIP7 = ~BIP3.
- Lane tracking:
  - AM j is on lane j.
  - Data block k (k from 0 after the group) is on lane k mod N_ALIGNERS.
  - A lane counter wraps at N_ALIGNERS-1 and is reset to 0 on entering INSERT and on entering DATA.
- Data blocks are passed unmodified. No sync-header checking is done.
- Stall behaviour:
  - i_valid low in DATA: no counting, o_valid=0.
  - AM spacing is measured in accepted blocks, not in cycles.

## Timing
- Registered outputs with 1-cycle latency: a block accepted at edge t appears on o_data after edge t.
- AM blocks are emitted on consecutive enabled cycles with o_valid=1. o_ready=0 throughout INSERT.
- i_enable low: o_ready=0. o_valid, o_am_flag and o_start_of_group are 0 on the next edge. State, counters and BIP accumulators hold. The group or stream resumes exactly where it stopped.
- Reset values: o_valid=0, o_data=0, o_am_flag=0, o_lane_id=0, o_start_of_group=0, state=INSERT, all counters and BIP registers =0.
- An asynchronous reset mid-group or mid-data discards all progress. The first enabled cycle after release emits the lane-0 AM.
- Counter terminal:
  - Terminal value is N_BLOCKS*N_ALIGNERS-1. It is compared only on an accepted block.
  - No wrap is possible inside DATA.

## Configuration
- Macro: AM_INSERT_BIP_EN.
- Defined:
  - N_ALIGNERS 8-bit BIP accumulators compute BIP3 per IEEE 802.3 clause 82.2.8.
  - Each accumulator covers all 66 bits of every block on that lane since its previous AM, including that AM.
  - The accumulator is re-seeded with the AM block it was just inserted into.
- Not defined: BIP3=8'h00 and BIP7=8'hFF constant. No accumulators are synthesized.

## Test plan
- Reset release, i_enable=1, i_valid=1 constantly, N_BLOCKS=4:
  - First 20 output blocks have o_am_flag=1 with lane 0..19.
  - o_start_of_group is high only on lane 0.
  - Lane-0 payload [23:0]=24'h2168C1.
  - o_ready is low for those 20 cycles.
  - Then 80 data blocks, then the next group.
- Passthrough: i_data = {2'b10, cycle count}, i_valid=1 → o_data equals i_data one cycle later, and o_lane_id cycles 0..19.
- Upstream gaps: i_valid toggles every cycle → the AM group starts after exactly 80 accepted blocks (about 160 cycles), and o_valid=0 on gap cycles.
- Enable drop during the group: i_enable low for 5 cycles after lane-7 AM → no output during the gap, and the next output is the lane-8 AM.
- Asynchronous reset pulse after 37 data blocks → all outputs are 0 without waiting for a clock edge, and the lane-0 AM is the first output after release.
- BIP: all-zero data payloads with header 2'b10.
  - With AM_INSERT_BIP_EN: BIP3 of every lane matches the bench model, and BIP7=~BIP3.
  - Without it: 8'h00/8'hFF on all lanes.
